// File: rtl/arm_defs_pkg.sv
// ----------------------------------------------------------------------------
// arm_defs: shared definitions for the ARM-subset pipeline.
//   - EXE_CMD opcodes understood by the execute-stage ALU
//   - shifter operand shift-type encodings
//   - bit positions of the N, Z, C and V flags inside a 4-bit status word
// ----------------------------------------------------------------------------
package arm_defs;

    // ALU opcodes (EXE_CMD)
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Shift types, Shift_operand[6:5]
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Flag positions in {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/val2_gen.sv
// ----------------------------------------------------------------------------
// val2_gen: combinational second-operand generator.
//   imm=1          : Shift_operand[7:0] rotated right by 2*Shift_operand[11:8]
//   mem_en=1       : zero-extended Shift_operand[11:0] (load/store offset)
//   otherwise      : val_rm shifted by Shift_operand[11:7], type [6:5]
// Ports:
//   val_rm        in  DATA_W  register operand
//   shift_operand in  12      shifter operand field
//   imm           in  1       immediate operand select
//   mem_en        in  1       load or store in flight
//   val2          out DATA_W  generated operand
// ----------------------------------------------------------------------------
module val2_gen
    import arm_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_en,
    output logic [DATA_W-1:0] val2
);

    logic [DATA_W-1:0]   imm_ext;
    logic [2*DATA_W-1:0] imm_dbl;
    logic [2*DATA_W-1:0] rm_dbl;
    logic [2*DATA_W-1:0] imm_rot;
    logic [2*DATA_W-1:0] rm_rot;
    logic [4:0]          imm_rot_amt;
    logic [4:0]          sh_amt;
    logic [1:0]          sh_type;

    assign imm_ext     = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    assign imm_rot_amt = {shift_operand[11:8], 1'b0};
    assign sh_amt      = shift_operand[11:7];
    assign sh_type     = shift_operand[6:5];

    // Rotation as a shift of the value concatenated with itself; the low
    // half is the rotated word. Amount 0 leaves the value untouched.
    assign imm_dbl = {imm_ext, imm_ext};
    assign rm_dbl  = {val_rm, val_rm};
    assign imm_rot = imm_dbl >> imm_rot_amt;
    assign rm_rot  = rm_dbl >> sh_amt;

    always_comb begin
        val2 = '0;
        if (imm) begin
            val2 = imm_rot[DATA_W-1:0];
        end else if (mem_en) begin
            val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        end else begin
            case (sh_type)
                SH_LSL:  val2 = val_rm << sh_amt;
                SH_LSR:  val2 = val_rm >> sh_amt;
                SH_ASR:  val2 = $unsigned($signed(val_rm) >>> sh_amt);
                default: val2 = rm_rot[DATA_W-1:0];
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage: execute stage of the 5-stage ARM-subset pipeline.
// Contains the Val2 generator, ALU, NZCV status register, branch target
// adder and the EX/MEM pipeline register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   freeze                   MEM stall: hold EX/MEM register and Status
//   *_IN                     ID/EX pipeline register outputs
//   Br_taken, Br_addr        combinational branch indication/target to IF
//   Status                   registered {N,Z,C,V} to ID
//   WB_EN, MEM_R_EN,
//   MEM_W_EN, ALU_Res,
//   St_val, Dest             EX/MEM pipeline register outputs
// ----------------------------------------------------------------------------
module exe_stage
    import arm_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic              B_IN,
    input  logic              S_IN,
    input  logic [3:0]        EXE_CMD_IN,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] Val_Rn_IN,
    input  logic [DATA_W-1:0] Val_Rm_IN,
    input  logic              imm_IN,
    input  logic [11:0]       Shift_operand_IN,
    input  logic [23:0]       Signed_imm_24_IN,
    input  logic [REG_W-1:0]  Dest_IN,
    output logic              Br_taken,
    output logic [DATA_W-1:0] Br_addr,
    output logic [3:0]        Status,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] St_val,
    output logic [REG_W-1:0]  Dest
);

    logic [DATA_W-1:0] val2;
    logic [DATA_W:0]   res33;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        nzcv_next;
    logic              c_cur;
    logic              c_new;
    logic              v_new;
    logic              cmd_known;
    logic              rn_msb;
    logic              v2_msb;
    logic              res_msb;

    // ------------------------------------------------------------------
    // Operand 2
    // ------------------------------------------------------------------
    val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
        .val_rm        (Val_Rm_IN),
        .shift_operand (Shift_operand_IN),
        .imm           (imm_IN),
        .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
        .val2          (val2)
    );

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign c_cur   = Status[FLAG_C];
    assign rn_msb  = Val_Rn_IN[DATA_W-1];
    assign v2_msb  = val2[DATA_W-1];
    assign res_msb = res33[DATA_W-1];

    always_comb begin
        res33     = '0;
        c_new     = Status[FLAG_C];
        v_new     = Status[FLAG_V];
        cmd_known = 1'b1;
        case (EXE_CMD_IN)
            CMD_MOV: res33 = {1'b0, val2};
            CMD_MVN: res33 = {1'b0, ~val2};
            CMD_ADD, CMD_ADC: begin
                res33 = {1'b0, Val_Rn_IN} + {1'b0, val2}
                      + {{DATA_W{1'b0}}, (EXE_CMD_IN == CMD_ADC) & c_cur};
                c_new = res33[DATA_W];
                v_new = (rn_msb == v2_msb) && (res_msb != rn_msb);
            end
            CMD_SUB, CMD_SBC: begin
                res33 = {1'b0, Val_Rn_IN} - {1'b0, val2}
                      - {{DATA_W{1'b0}}, (EXE_CMD_IN == CMD_SBC) & ~c_cur};
                // Bit 32 is the borrow; ARM carry is its complement.
                c_new = ~res33[DATA_W];
                v_new = (rn_msb != v2_msb) && (res_msb != rn_msb);
            end
            CMD_AND: res33 = {1'b0, Val_Rn_IN & val2};
            CMD_ORR: res33 = {1'b0, Val_Rn_IN | val2};
            CMD_EOR: res33 = {1'b0, Val_Rn_IN ^ val2};
            default: cmd_known = 1'b0;
        endcase
    end

    assign alu_res = res33[DATA_W-1:0];

    always_comb begin
        nzcv_next = Status;
        if (cmd_known) begin
            nzcv_next[FLAG_N] = alu_res[DATA_W-1];
            nzcv_next[FLAG_Z] = (alu_res == '0);
            nzcv_next[FLAG_C] = c_new;
            nzcv_next[FLAG_V] = v_new;
        end
    end

    // ------------------------------------------------------------------
    // Status register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Status <= 4'b0000;
        end else if (S_IN && !freeze) begin
            Status <= nzcv_next;
        end
    end

    // ------------------------------------------------------------------
    // Branch target: PC+4 plus word offset, wraps at 32 bits
    // ------------------------------------------------------------------
    assign Br_taken = B_IN;
    assign Br_addr  = PC_IN + {{(DATA_W-26){Signed_imm_24_IN[23]}},
                               Signed_imm_24_IN, 2'b00};

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            ALU_Res  <= '0;
            St_val   <= '0;
            Dest     <= '0;
        end else if (!freeze) begin
            WB_EN    <= WB_EN_IN;
            MEM_R_EN <= MEM_R_EN_IN;
            MEM_W_EN <= MEM_W_EN_IN;
            ALU_Res  <= alu_res;
            St_val   <= Val_Rm_IN;
            Dest     <= Dest_IN;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic [3:0]  Status;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_Res, St_val;
    logic [3:0]  Dest;

    int pass_cnt;
    int total_cnt;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .WB_EN_IN         (WB_EN_IN),
        .MEM_R_EN_IN      (MEM_R_EN_IN),
        .MEM_W_EN_IN      (MEM_W_EN_IN),
        .B_IN             (B_IN),
        .S_IN             (S_IN),
        .EXE_CMD_IN       (EXE_CMD_IN),
        .PC_IN            (PC_IN),
        .Val_Rn_IN        (Val_Rn_IN),
        .Val_Rm_IN        (Val_Rm_IN),
        .imm_IN           (imm_IN),
        .Shift_operand_IN (Shift_operand_IN),
        .Signed_imm_24_IN (Signed_imm_24_IN),
        .Dest_IN          (Dest_IN),
        .Br_taken         (Br_taken),
        .Br_addr          (Br_addr),
        .Status           (Status),
        .WB_EN            (WB_EN),
        .MEM_R_EN         (MEM_R_EN),
        .MEM_W_EN         (MEM_W_EN),
        .ALU_Res          (ALU_Res),
        .St_val           (St_val),
        .Dest             (Dest)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: one ID/EX instruction
    task automatic drive(input logic [3:0] cmd, input logic s, input logic wb,
                         input logic mr, input logic mw, input logic [31:0] rn,
                         input logic [31:0] rm, input logic im,
                         input logic [11:0] sh, input logic [3:0] dst);
        EXE_CMD_IN       = cmd;
        S_IN             = s;
        WB_EN_IN         = wb;
        MEM_R_EN_IN      = mr;
        MEM_W_EN_IN      = mw;
        Val_Rn_IN        = rn;
        Val_Rm_IN        = rm;
        imm_IN           = im;
        Shift_operand_IN = sh;
        Dest_IN          = dst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // get something non-zero into every register first: MVNS imm 0xFF
        drive(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 12'h0FF, 4'd5);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'hFFFF_FF00 || Status !== 4'b1000)
            $display("FAIL pre_reset_load: ALU_Res=%h Status=%b want FFFFFF00 1000", ALU_Res, Status);
        else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({WB_EN, MEM_R_EN, MEM_W_EN} !== 3'b000 || ALU_Res !== 32'h0 ||
            St_val !== 32'h0 || Dest !== 4'h0 || Status !== 4'b0000)
            $display("FAIL async_reset: ctl=%b ALU_Res=%h St_val=%h Dest=%h Status=%b want all 0",
                     {WB_EN, MEM_R_EN, MEM_W_EN}, ALU_Res, St_val, Dest, Status);
        else pass_cnt++;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_flags();
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 4'd2);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'h8000_0000 || Status !== 4'b1001 || WB_EN !== 1'b1 || Dest !== 4'd2)
            $display("FAIL add_overflow: ALU_Res=%h Status=%b WB=%b Dest=%0d want 80000000 1001 1 2",
                     ALU_Res, Status, WB_EN, Dest);
        else pass_cnt++;
    endtask

    task automatic test_sub_adc();
        // SUBS 5-5 register operand, no shift
        drive(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 12'h000, 4'd1);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'h0 || Status !== 4'b0110)
            $display("FAIL sub_zero_carry: ALU_Res=%h Status=%b want 00000000 0110", ALU_Res, Status);
        else pass_cnt++;
        // MVNS #0: N/Z update, C stays 1, V stays 0
        drive(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 12'h000, 4'd1);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'hFFFF_FFFF || Status !== 4'b1010)
            $display("FAIL mvn_holds_c: ALU_Res=%h Status=%b want FFFFFFFF 1010", ALU_Res, Status);
        else pass_cnt++;
        // undefined opcode with S=1: result 0, flags untouched
        drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0, 12'h000, 4'd1);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'h0 || Status !== 4'b1010)
            $display("FAIL unknown_cmd: ALU_Res=%h Status=%b want 00000000 1010", ALU_Res, Status);
        else pass_cnt++;
        // ADCS 1+1+C(1)
        drive(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 1'b1, 12'h001, 4'd1);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'd3 || Status !== 4'b0000)
            $display("FAIL adc_carry_in: ALU_Res=%h Status=%b want 00000003 0000", ALU_Res, Status);
        else pass_cnt++;
        // SBCS 5-3-~C(C=0) = 1, no borrow -> C=1
        drive(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 1'b1, 12'h003, 4'd1);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'd1 || Status !== 4'b0010)
            $display("FAIL sbc_borrow_in: ALU_Res=%h Status=%b want 00000001 0010", ALU_Res, Status);
        else pass_cnt++;
    endtask

    task automatic test_shifter();
        logic [11:0] sh_tab  [4] = '{12'h0C0, 12'h0E0, 12'h0A0, 12'h080};
        logic [31:0] exp_tab [4] = '{32'hC000_0000, 32'hC000_0000, 32'h4000_0000, 32'h0000_0002};
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0001, 1'b0, sh_tab[i], 4'd4);
            tick();
            total_cnt++;
            if (ALU_Res !== exp_tab[i] || Status !== 4'b0010)
                $display("FAIL shift_%0d: sh=%h ALU_Res=%h Status=%b want %h 0010",
                         i, sh_tab[i], ALU_Res, Status, exp_tab[i]);
            else pass_cnt++;
        end
        // immediate 0xFF rotated right by 4
        drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b1, 12'h2FF, 4'd4);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'hF000_000F)
            $display("FAIL imm_rotate: ALU_Res=%h want F000000F", ALU_Res);
        else pass_cnt++;
        // load address: 12-bit zero-extended offset, shifter bits ignored
        drive(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h5, 1'b0, 12'hABC, 4'd6);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'h0000_1ABC || MEM_R_EN !== 1'b1 || Dest !== 4'd6)
            $display("FAIL ldr_offset: ALU_Res=%h MEM_R=%b Dest=%0d want 00001ABC 1 6",
                     ALU_Res, MEM_R_EN, Dest);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        PC_IN = 32'h100;
        Signed_imm_24_IN = 24'hFFFFFE;
        B_IN = 1'b1;
        #1;
        total_cnt++;
        if (Br_taken !== 1'b1 || Br_addr !== 32'h0000_00F8)
            $display("FAIL branch_back: taken=%b addr=%h want 1 000000F8", Br_taken, Br_addr);
        else pass_cnt++;
        Signed_imm_24_IN = 24'h000010;
        B_IN = 1'b0;
        #1;
        total_cnt++;
        if (Br_taken !== 1'b0 || Br_addr !== 32'h0000_0140)
            $display("FAIL branch_fwd: taken=%b addr=%h want 0 00000140", Br_taken, Br_addr);
        else pass_cnt++;
        PC_IN = 32'h0;
        Signed_imm_24_IN = 24'h0;
    endtask

    task automatic test_freeze();
        // STR: address Rn+4, store data Rm; status entering is 0010
        drive(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 12'h004, 4'd3);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'h24 || St_val !== 32'hDEAD_BEEF || MEM_W_EN !== 1'b1 || WB_EN !== 1'b0)
            $display("FAIL str_load: ALU_Res=%h St_val=%h MEM_W=%b WB=%b want 24 DEADBEEF 1 0",
                     ALU_Res, St_val, MEM_W_EN, WB_EN);
        else pass_cnt++;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd100 + i, 1'b0, 12'h000, 4'd9);
            tick();
            total_cnt++;
            if (ALU_Res !== 32'h24 || St_val !== 32'hDEAD_BEEF || MEM_W_EN !== 1'b1 ||
                WB_EN !== 1'b0 || Dest !== 4'd3 || Status !== 4'b0010)
                $display("FAIL freeze_hold_%0d: ALU_Res=%h St_val=%h MEM_W=%b Dest=%0d Status=%b want 24 DEADBEEF 1 3 0010",
                         i, ALU_Res, St_val, MEM_W_EN, Dest, Status);
            else pass_cnt++;
        end
        freeze = 1'b0;
        // SUBS 1-2 -> -1 with borrow
        drive(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 1'b0, 12'h000, 4'd7);
        tick();
        total_cnt++;
        if (ALU_Res !== 32'hFFFF_FFFF || St_val !== 32'd2 || Dest !== 4'd7 ||
            MEM_W_EN !== 1'b0 || Status !== 4'b1000)
            $display("FAIL freeze_release: ALU_Res=%h St_val=%h Dest=%0d MEM_W=%b Status=%b want FFFFFFFF 2 7 0 1000",
                     ALU_Res, St_val, Dest, MEM_W_EN, Status);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h000, 4'd0);
        tick();
        total_cnt++;
        if ({WB_EN, MEM_R_EN, MEM_W_EN} !== 3'b000 || ALU_Res !== 32'h0 || Status !== 4'b1000)
            $display("FAIL bubble: ctl=%b ALU_Res=%h Status=%b want 000 0 1000",
                     {WB_EN, MEM_R_EN, MEM_W_EN}, ALU_Res, Status);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_freeze();
        drive(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h77, 1'b1, 12'h055, 4'd8);
        tick();
        freeze = 1'b1;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({WB_EN, MEM_R_EN, MEM_W_EN} !== 3'b000 || ALU_Res !== 32'h0 ||
            St_val !== 32'h0 || Dest !== 4'h0 || Status !== 4'b0000)
            $display("FAIL reset_in_freeze: ctl=%b ALU_Res=%h St_val=%h Dest=%h Status=%b want all 0",
                     {WB_EN, MEM_R_EN, MEM_W_EN}, ALU_Res, St_val, Dest, Status);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        freeze = 1'b0;
        B_IN = 1'b0;
        PC_IN = 32'h0;
        Signed_imm_24_IN = 24'h0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h000, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_add_flags();
        test_sub_adc();
        test_shifter();
        test_branch();
        test_freeze();
        test_bubble();
        test_reset_in_freeze();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline. It consumes the ID/EX pipeline register outputs (control bits, EXE_CMD, Val_Rn, Val_Rm, imm, shift operand, 24-bit branch offset, Dest, PC).
- It contains:
  - the Val2 generator
  - the ALU
  - the NZCV status register
  - the branch target adder
  - the EX/MEM pipeline register feeding the memory stage
- Branch-taken indication and target go back to IF combinationally. Status flags go back to ID for condition evaluation.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- REG_W, 4, register-index width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- freeze, in, 1, MEM-stage stall. When high, hold the EX/MEM register and the status register.
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, in, 1 each, control bits from ID/EX.
- EXE_CMD_IN, in, 4, ALU opcode.
- PC_IN, in, 32, PC+4 of the instruction.
- Val_Rn_IN, Val_Rm_IN, in, 32 each, operand values.
- imm_IN, in, 1, immediate operand select.
- Shift_operand_IN, in, 12, shifter operand field.
- Signed_imm_24_IN, in, 24, branch offset.
- Dest_IN, in, 4, destination register.
- Br_taken, out, 1, equals B_IN (combinational).
- Br_addr, out, 32, branch target (combinational).
- Status, out, 4, registered {N,Z,C,V}.
- WB_EN, MEM_R_EN, MEM_W_EN, out, 1 each, registered control.
- ALU_Res, out, 32, registered ALU result.
- St_val, out, 32, registered Val_Rm (store data).
- Dest, out, 4, registered destination.

Behaviour:
- Reset: rst is asynchronous and active-high. All registered outputs and Status are 0. Reset mid-stall or mid-instruction wins over everything.
- Val2 (combinational):
  - imm_IN=1: zero-extend Shift_operand[7:0], then rotate right by 2*Shift_operand[11:8].
  - Else if MEM_R_EN_IN|MEM_W_EN_IN: zero-extend Shift_operand[11:0].
  - Else: shift Val_Rm_IN by amount Shift_operand[11:7]. Shift type from [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Shift amount 0 means no shift for every type.
- ALU, result and flags computed on 33 bits:
  - 0001 MOV: res = Val2.
  - 1001 MVN: res = ~Val2.
  - 0010 ADD (also LDR/STR): Rn + Val2.
  - 0011 ADC: Rn + Val2 + C.
  - 0100 SUB/CMP: Rn - Val2.
  - 0101 SBC: Rn - Val2 - ~C.
  - 0110 AND/TST, 0111 ORR, 1000 EOR.
  - Any other code: res = 0, flags unchanged.
- Flags:
  - N = res[31]. Z = (res == 0).
  - C: carry-out for ADD/ADC. For SUB/SBC, C is the inverted borrow (1 when no borrow).
  - V: signed overflow for the arithmetic ops.
  - Logical ops and MOV/MVN update only N and Z; C and V are held.
- Status register: loads the new NZCV at posedge clk when S_IN=1 and freeze=0. Otherwise it holds.
- Branch path: Br_addr = PC_IN + (sign_extend(Signed_imm_24_IN) << 2), with 32-bit wrap-around. Br_taken = B_IN. Flushing IF/ID and ID/EX on a taken branch is the hazard unit's job, not this block's.
- EX/MEM register: latency 1 cycle. At posedge with freeze=0 it loads WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, St_val (=Val_Rm_IN) and Dest. With freeze=1 every output holds.
- A bubble (all control bits 0) propagates as a bubble. Status does not change because S_IN=0.
- freeze and S_IN both high in the same cycle: the status update is suppressed.

Decomposition:
- Shared package arm_defs:
  - EXE_CMD localparams (CMD_MOV … CMD_EOR)
  - shift-type constants (SH_LSL, SH_LSR, SH_ASR, SH_ROR)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module val2_gen: combinational Val2 generator, instantiated once. Everything else stays in exe_stage.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> every output 0 immediately, Status=0000.
- ADD with flags: Rn=0x7FFFFFFF, imm=1, Shift_operand=0x001, EXE_CMD=0010, S=1 -> next cycle ALU_Res=0x80000000, Status=1001 (N,V).
- SUB setting carry: Rn=5, Rm=5, register operand with no shift, CMD=0100, S=1 -> ALU_Res=0, Status=0110 (Z,C). Then ADC with Rn=1, Val2=1 -> ALU_Res=3.
- Shifter: Rm=0x80000001, Shift_operand = amount 1, ASR -> Val2=0xC0000000. ROR 1 -> 0xC0000000. LSR 1 -> 0x40000000. Check each with a MOV.
- Branch: PC_IN=0x100, Signed_imm_24=0xFFFFFE, B_IN=1 -> Br_taken=1, Br_addr=0xF8 in the same cycle.
- Freeze: load a STR (MEM_W_EN=1, Rn=0x20, imm offset 4), then raise freeze for 3 cycles with changing inputs and S=1 -> ALU_Res stays 0x24, St_val stays held, Status unchanged. Release freeze -> next instruction is captured.
